veer_trace_fifo: RTL and testbench
==================================

# veer_trace_fifo

Parametrised successor to the fixed 3-lane retire-trace packet. It accepts up to LANES retired instructions per cycle, compacts the valid lanes in lane order, and buffers them as single-instruction records in a DEPTH-entry FIFO. Records drain one per cycle over a valid/ready port to the trace encoder or debug sink. A drop or stall policy is selectable at run time, and lost packets are counted and flagged.

## Interface
Parameters:
- LANES, 3, retire lanes per cycle (1..8); lane 0 is oldest.
- DEPTH, 16, FIFO entries; power of two, DEPTH >= LANES.
- OVF_W, 16, width of the overflow counter.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- stall_mode  in  1  1 = backpressure source; 0 = drop whole packet on insufficient space.
- tr_valid  in  LANES  per-lane retire valid; non-contiguous patterns allowed.
- tr_insn  in  32*LANES  per-lane instruction.
- tr_addr  in  32*LANES  per-lane PC.
- tr_exc  in  LANES  per-lane exception.
- tr_ecause  in  5*LANES  per-lane cause.
- tr_intr  in  LANES  per-lane interrupt.
- tr_tval  in  32  shared tval; attached only to records with exc or intr set, 0 otherwise.
- tr_ready  out  1  stall mode: count <= DEPTH-LANES; drop mode: constant 1.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  sink accepts the head record.
- out_insn, out_addr, out_tval  out  32 each  head record fields.
- out_exc, out_intr  out  1 each.
- out_ecause  out  5.
- out_lost  out  1  one or more packets were dropped immediately before this record.
- count  out  $clog2(DEPTH+1)  current occupancy.
- ovf_cnt  out  OVF_W  saturating count of dropped packets.
- ovf_clr  in  1  synchronous clear of ovf_cnt.

## Operation
- N = popcount(tr_valid). Packet offered when N != 0.
- Accept condition:
  - Stall mode: tr_ready is high.
  - Drop mode: N <= DEPTH - count.
- count is sampled at the start of the cycle. A same-cycle pop is not credited.
- Acceptance is all-or-nothing. Accepted lanes are written to wr_ptr, wr_ptr+1, …, wr_ptr+N-1 (mod DEPTH), in ascending lane order.
- Drop (drop mode, offered, not accepted):
  - Nothing is written.
  - ovf_cnt increments, saturating at all-ones.
  - lost_pend sets.
- Stall mode, offered, tr_ready low: no write and no drop. The source holds its packet.
- lost_pend is stored into the first record of the next accepted packet, then cleared. If lost_pend is set and a new drop occurs in the same cycle, it stays set.
- Pop: out_valid && out_ready. rd_ptr advances by 1 (mod DEPTH).
- Same-cycle push and pop: count_next = count + N - pop.
- ovf_clr with a same-cycle drop: ovf_cnt_next = 1. ovf_clr does not clear lost_pend.
- stall_mode changes take effect in the same cycle. Buffered contents are unaffected.
- Out data fields are forced to 0 while out_valid = 0.

## Timing
- Reset values: wr_ptr = rd_ptr = count = 0, ovf_cnt = 0, lost_pend = 0, out_valid = 0, all out data = 0, tr_ready = 1. Storage is not reset.
- Latency: a record accepted at edge k is visible on out_* after edge k (1 cycle).
- Head data is driven directly from storage; no extra output register.
- Throughput: in 1 packet/cycle (up to LANES records), out 1 record/cycle.
- tr_ready depends only on count and stall_mode (registered state). It has no combinational path from tr_valid or out_ready.
- Pointers are $clog2(DEPTH) bits and wrap naturally.
- Full: count == DEPTH, so no packet fits. Empty: count == 0, out_valid = 0, and a pop is ignored.
- Reset asserted mid-operation discards all contents asynchronously, and all outputs return to their reset values.

## Structure
- veer_types gains:
  - trace_rec_t (insn, addr, exc, ecause, intr, tval, lost; 104 bits).
  - Parametric trace_pkt_t replacement fields sized by LANES, via a packed array of per-lane sub-structs.
- Sub-module veer_trace_compact: combinational. Computes N and per-lane write offsets (prefix popcount of tr_valid), and builds the LANES trace_rec_t candidates.
- veer_trace_fifo holds storage, pointers, count, acceptance logic, overflow counter and lost_pend.

## Test plan
- LANES=3, DEPTH=16, drop mode. tr_valid=3'b101, insn A/B, out_ready=1 -> A next cycle, then B; count returns to 0; lost=0.
- Fill to count=14, then offer tr_valid=3'b111, out_ready=0, drop mode -> dropped, ovf_cnt=1, count=14. Then offer 3'b011 -> accepted, count=16; first new record has lost=1, second has lost=0.
- Same state in stall mode -> tr_ready=0 at count=14; no drop, ovf_cnt unchanged. Pop 1 -> tr_ready=1; packet accepted, count=16.
- Wrap: 40 cycles of 3'b111 with out_ready=1 -> ordered output of all 120 records, pointers wrap, no loss.
- OVF_W=2 with 5 drops -> ovf_cnt saturates at 3. ovf_clr together with a drop -> ovf_cnt=1.
- Assert rst with count=7 mid-stream -> out_valid=0, count=0, out data=0, tr_ready=1 immediately.

Source files
------------

// File: rtl/veer_trace_fifo_pkg.sv
// Shared types for the retire-trace FIFO: per-lane inputs and buffered
// single-instruction trace records.
package veer_trace_fifo_pkg;

    typedef struct packed {
        logic [31:0] insn;
        logic [31:0] addr;
        logic        exc;
        logic [4:0]  ecause;
        logic        intr;
        logic [31:0] tval;
        logic        lost;
    } trace_rec_t;

    localparam int REC_W = $bits(trace_rec_t);

    typedef struct packed {
        logic        valid;
        logic [31:0] insn;
        logic [31:0] addr;
        logic        exc;
        logic [4:0]  ecause;
        logic        intr;
    } trace_lane_t;

    // tval is only meaningful for trapping records
    function automatic trace_rec_t lane_to_rec(
        input trace_lane_t l,
        input logic [31:0] tval
    );
        trace_rec_t r;
        r.insn   = l.insn;
        r.addr   = l.addr;
        r.exc    = l.exc;
        r.ecause = l.ecause;
        r.intr   = l.intr;
        r.tval   = (l.exc || l.intr) ? tval : 32'd0;
        r.lost   = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/veer_trace_fifo_compact.sv
// Lane compaction: valid-lane count, prefix write offsets and
// per-lane record candidates.
module veer_trace_compact
    import veer_trace_fifo_pkg::*;
#(
    parameter int LANES = 3,
    parameter int OW    = 2
) (
    input  trace_lane_t [LANES-1:0]         i_lanes,
    input  logic        [31:0]              i_tval,
    output logic        [OW-1:0]            o_n,
    output logic        [LANES-1:0][OW-1:0] o_off,
    output trace_rec_t  [LANES-1:0]         o_recs
);

    always_comb begin
        logic [OW-1:0] sum;
        sum    = '0;
        o_off  = '0;
        o_recs = '0;
        for (int i = 0; i < LANES; i++) begin
            o_off[i]  = sum;
            sum       = sum + OW'(i_lanes[i].valid);
            o_recs[i] = lane_to_rec(i_lanes[i], i_tval);
        end
        o_n = sum;
    end

endmodule

// File: rtl/veer_trace_fifo.sv
// Retire-trace FIFO: compacts up to LANES retired instructions per cycle
// into single-record entries, with drop/stall overflow policy.
module veer_trace_fifo
    import veer_trace_fifo_pkg::*;
#(
    parameter int LANES = 3,
    parameter int DEPTH = 16,
    parameter int OVF_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       stall_mode,
    input  logic [LANES-1:0]           tr_valid,
    input  logic [32*LANES-1:0]        tr_insn,
    input  logic [32*LANES-1:0]        tr_addr,
    input  logic [LANES-1:0]           tr_exc,
    input  logic [5*LANES-1:0]         tr_ecause,
    input  logic [LANES-1:0]           tr_intr,
    input  logic [31:0]                tr_tval,
    output logic                       tr_ready,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_insn,
    output logic [31:0]                out_addr,
    output logic [31:0]                out_tval,
    output logic                       out_exc,
    output logic                       out_intr,
    output logic [4:0]                 out_ecause,
    output logic                       out_lost,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [OVF_W-1:0]           ovf_cnt,
    input  logic                       ovf_clr
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int OW = $clog2(LANES+1);

    trace_rec_t              r_mem [DEPTH];
    logic [PW-1:0]           r_wr;
    logic [PW-1:0]           r_rd;
    logic [CW-1:0]           r_count;
    logic [OVF_W-1:0]        r_ovf;
    logic                    r_lost;

    trace_lane_t [LANES-1:0]         w_lanes;
    logic        [OW-1:0]            w_n;
    logic        [LANES-1:0][OW-1:0] w_off;
    trace_rec_t  [LANES-1:0]         w_recs;
    trace_rec_t  [LANES-1:0]         w_wrec;
    trace_rec_t                      w_head;
    trace_rec_t                      w_out;
    logic                            w_offered;
    logic                            w_fits;
    logic                            w_accept;
    logic                            w_drop;
    logic                            w_pop;
    logic [CW-1:0]                   w_add;

    always_comb begin
        w_lanes = '0;
        for (int i = 0; i < LANES; i++) begin
            w_lanes[i].valid  = tr_valid[i];
            w_lanes[i].insn   = tr_insn[32*i +: 32];
            w_lanes[i].addr   = tr_addr[32*i +: 32];
            w_lanes[i].exc    = tr_exc[i];
            w_lanes[i].ecause = tr_ecause[5*i +: 5];
            w_lanes[i].intr   = tr_intr[i];
        end
    end

    veer_trace_compact #(
        .LANES (LANES),
        .OW    (OW)
    ) u_compact (
        .i_lanes (w_lanes),
        .i_tval  (tr_tval),
        .o_n     (w_n),
        .o_off   (w_off),
        .o_recs  (w_recs)
    );

    // tr_ready must stay a function of registered state only
    assign tr_ready  = stall_mode ? (r_count <= CW'(DEPTH - LANES)) : 1'b1;
    assign w_offered = (w_n != '0);
    assign w_fits    = (CW'(w_n) <= (CW'(DEPTH) - r_count));
    assign w_accept  = w_offered && (stall_mode ? tr_ready : w_fits);
    assign w_drop    = w_offered && !stall_mode && !w_fits;
    assign w_pop     = out_valid && out_ready;
    assign w_add     = w_accept ? CW'(w_n) : '0;

    always_comb begin
        w_wrec = w_recs;
        for (int i = 0; i < LANES; i++) begin
            w_wrec[i].lost = r_lost && (w_off[i] == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int i = 0; i < LANES; i++) begin
                if (tr_valid[i]) begin
                    r_mem[r_wr + PW'(w_off[i])] <= w_wrec[i];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            r_ovf   <= '0;
            r_lost  <= 1'b0;
        end else begin
            if (w_accept) r_wr <= r_wr + PW'(w_n);
            if (w_pop) r_rd <= r_rd + PW'(1);
            r_count <= r_count + w_add - CW'(w_pop);
            if (ovf_clr) begin
                r_ovf <= w_drop ? OVF_W'(1) : '0;
            end else if (w_drop && (r_ovf != '1)) begin
                r_ovf <= r_ovf + OVF_W'(1);
            end
            if (w_drop) begin
                r_lost <= 1'b1;
            end else if (w_accept) begin
                r_lost <= 1'b0;
            end
        end
    end

    assign out_valid  = (r_count != '0);
    assign w_head     = r_mem[r_rd];
    assign w_out      = out_valid ? w_head : '0;
    assign out_insn   = w_out.insn;
    assign out_addr   = w_out.addr;
    assign out_tval   = w_out.tval;
    assign out_exc    = w_out.exc;
    assign out_intr   = w_out.intr;
    assign out_ecause = w_out.ecause;
    assign out_lost   = w_out.lost;
    assign count      = r_count;
    assign ovf_cnt    = r_ovf;

endmodule

// File: tb/tb_veer_trace_fifo.sv
// Directed self-checking bench for veer_trace_fifo (LANES=3, DEPTH=16,
// OVF_W=2).
module tb_veer_trace_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_mode;
    logic [2:0]  tr_valid;
    logic [95:0] tr_insn;
    logic [95:0] tr_addr;
    logic [2:0]  tr_exc;
    logic [14:0] tr_ecause;
    logic [2:0]  tr_intr;
    logic [31:0] tr_tval;
    logic        tr_ready;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_insn;
    logic [31:0] out_addr;
    logic [31:0] out_tval;
    logic        out_exc;
    logic        out_intr;
    logic [4:0]  out_ecause;
    logic        out_lost;
    logic [4:0]  count;
    logic [1:0]  ovf_cnt;
    logic        ovf_clr;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    veer_trace_fifo #(
        .LANES (3),
        .DEPTH (16),
        .OVF_W (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stall_mode (stall_mode),
        .tr_valid   (tr_valid),
        .tr_insn    (tr_insn),
        .tr_addr    (tr_addr),
        .tr_exc     (tr_exc),
        .tr_ecause  (tr_ecause),
        .tr_intr    (tr_intr),
        .tr_tval    (tr_tval),
        .tr_ready   (tr_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_insn   (out_insn),
        .out_addr   (out_addr),
        .out_tval   (out_tval),
        .out_exc    (out_exc),
        .out_intr   (out_intr),
        .out_ecause (out_ecause),
        .out_lost   (out_lost),
        .count      (count),
        .ovf_cnt    (ovf_cnt),
        .ovf_clr    (ovf_clr)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        tr_valid  = '0;
        tr_insn   = '0;
        tr_addr   = '0;
        tr_exc    = '0;
        tr_ecause = '0;
        tr_intr   = '0;
        tr_tval   = '0;
    endtask

    task automatic set_pkt(input logic [2:0] v, input logic [31:0] base);
        clr_in();
        tr_valid = v;
        for (int i = 0; i < 3; i++) begin
            tr_insn[32*i +: 32] = base + 32'(i);
            tr_addr[32*i +: 32] = (base + 32'(i)) << 2;
        end
    endtask

    task automatic push(input logic [2:0] v, input logic [31:0] base);
        set_pkt(v, base);
        tick();
        clr_in();
    endtask

    initial begin
        int p;
        int idx;
        logic fire;

        rst        = 1'b1;
        stall_mode = 1'b0;
        out_ready  = 1'b0;
        ovf_clr    = 1'b0;
        clr_in();
        #1;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_ready", 64'(tr_ready), 64'd1);
        chk("rst_ovf", 64'(ovf_cnt), 64'd0);
        chk("rst_insn", 64'(out_insn), 64'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // non-contiguous 3'b101 packet, lane 2 trapping
        out_ready = 1'b1;
        set_pkt(3'b101, 32'hA000);
        tr_exc[2]         = 1'b1;
        tr_ecause[14:10]  = 5'h0b;
        tr_tval           = 32'h1234;
        tick();
        clr_in();
        chk("p1_count", 64'(count), 64'd2);
        chk("p1_insnA", 64'(out_insn), 64'hA000);
        chk("p1_addrA", 64'(out_addr), 64'h28000);
        chk("p1_tvalA", 64'(out_tval), 64'd0);
        chk("p1_lostA", 64'(out_lost), 64'd0);
        tick();
        chk("p1_insnB", 64'(out_insn), 64'hA002);
        chk("p1_excB", 64'(out_exc), 64'd1);
        chk("p1_ecB", 64'(out_ecause), 64'h0b);
        chk("p1_tvalB", 64'(out_tval), 64'h1234);
        chk("p1_lostB", 64'(out_lost), 64'd0);
        tick();
        chk("p1_empty", 64'(count), 64'd0);
        chk("p1_zero", 64'(out_insn), 64'd0);

        // drop mode overflow
        out_ready = 1'b0;
        push(3'b111, 32'h1000);
        push(3'b111, 32'h1003);
        push(3'b111, 32'h1006);
        push(3'b111, 32'h1009);
        push(3'b011, 32'h100C);
        chk("d_count14", 64'(count), 64'd14);
        chk("d_ready", 64'(tr_ready), 64'd1);
        push(3'b111, 32'hBAD0);
        chk("d_dropcnt", 64'(count), 64'd14);
        chk("d_ovf1", 64'(ovf_cnt), 64'd1);
        push(3'b011, 32'hC000);
        chk("d_count16", 64'(count), 64'd16);
        out_ready = 1'b1;
        for (int j = 0; j < 14; j++) begin
            chk("d_fill", 64'(out_insn), 64'(32'h1000 + 32'(j)));
            chk("d_filllost", 64'(out_lost), 64'd0);
            tick();
        end
        chk("d_C", 64'(out_insn), 64'hC000);
        chk("d_Clost", 64'(out_lost), 64'd1);
        tick();
        chk("d_D", 64'(out_insn), 64'hC001);
        chk("d_Dlost", 64'(out_lost), 64'd0);
        tick();
        chk("d_empty", 64'(count), 64'd0);

        // stall mode backpressure
        out_ready  = 1'b0;
        stall_mode = 1'b1;
        push(3'b111, 32'h1000);
        push(3'b111, 32'h1003);
        push(3'b111, 32'h1006);
        push(3'b111, 32'h1009);
        push(3'b011, 32'h100C);
        chk("s_count14", 64'(count), 64'd14);
        chk("s_ready0", 64'(tr_ready), 64'd0);
        push(3'b111, 32'hBAD0);
        chk("s_hold", 64'(count), 64'd14);
        chk("s_ovf", 64'(ovf_cnt), 64'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("s_count13", 64'(count), 64'd13);
        chk("s_ready1", 64'(tr_ready), 64'd1);
        push(3'b111, 32'h2000);
        chk("s_count16", 64'(count), 64'd16);
        chk("s_readyF", 64'(tr_ready), 64'd0);
        out_ready = 1'b1;
        for (int j = 1; j < 14; j++) begin
            chk("s_fill", 64'(out_insn), 64'(32'h1000 + 32'(j)));
            tick();
        end
        for (int j = 0; j < 3; j++) begin
            chk("s_pkt", 64'(out_insn), 64'(32'h2000 + 32'(j)));
            chk("s_pktlost", 64'(out_lost), 64'd0);
            tick();
        end
        chk("s_empty", 64'(count), 64'd0);

        // long stream through wrapping pointers, stall mode
        p   = 0;
        idx = 0;
        for (int cyc = 0; cyc < 400 && idx < 120; cyc++) begin
            if (p < 40) set_pkt(3'b111, 32'h5000_0000 + 32'(3 * p));
            else clr_in();
            if (out_valid) begin
                chk("w_insn", 64'(out_insn),
                    64'(32'h5000_0000 + 32'(idx)));
                chk("w_lost", 64'(out_lost), 64'd0);
                idx++;
            end
            fire = (p < 40) && tr_ready;
            tick();
            if (fire) p++;
        end
        clr_in();
        chk("w_total", 64'(idx), 64'd120);
        chk("w_empty", 64'(count), 64'd0);
        chk("w_ovf", 64'(ovf_cnt), 64'd1);

        // overflow counter saturation and clear
        stall_mode = 1'b0;
        out_ready  = 1'b0;
        ovf_clr    = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("o_clr", 64'(ovf_cnt), 64'd0);
        for (int j = 0; j < 5; j++) push(3'b111, 32'h3000 + 32'(3 * j));
        push(3'b001, 32'h300F);
        chk("o_full", 64'(count), 64'd16);
        push(3'b001, 32'hBAD0);
        chk("o_sat1", 64'(ovf_cnt), 64'd1);
        push(3'b100, 32'hBAD0);
        chk("o_sat2", 64'(ovf_cnt), 64'd2);
        push(3'b010, 32'hBAD0);
        chk("o_sat3", 64'(ovf_cnt), 64'd3);
        push(3'b001, 32'hBAD0);
        chk("o_sat4", 64'(ovf_cnt), 64'd3);
        push(3'b111, 32'hBAD0);
        chk("o_sat5", 64'(ovf_cnt), 64'd3);
        ovf_clr = 1'b1;
        push(3'b001, 32'hBAD0);
        ovf_clr = 1'b0;
        chk("o_clrdrop", 64'(ovf_cnt), 64'd1);
        chk("o_count", 64'(count), 64'd16);

        // asynchronous reset mid-stream
        out_ready = 1'b1;
        for (int j = 0; j < 9; j++) tick();
        out_ready  = 1'b0;
        stall_mode = 1'b1;
        chk("r_count7", 64'(count), 64'd7);
        chk("r_head", 64'(out_insn), 64'h3009);
        #2;
        rst = 1'b1;
        #1;
        chk("r_valid", 64'(out_valid), 64'd0);
        chk("r_count", 64'(count), 64'd0);
        chk("r_insn", 64'(out_insn), 64'd0);
        chk("r_addr", 64'(out_addr), 64'd0);
        chk("r_ready", 64'(tr_ready), 64'd1);
        chk("r_ovf", 64'(ovf_cnt), 64'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("r_after", 64'(out_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
